// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared sizing and constants for the register destination scoreboard.
package reg_dest_scoreboard_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 2;
    localparam int PCNT_W   = 7;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
endpackage

// File: rtl/reg_dest_scoreboard_if.sv
// Issue / write-back / status bundle between the pipeline and the scoreboard.
interface reg_dest_scoreboard_if;
    import reg_dest_scoreboard_pkg::*;

    logic                 issue_valid;
    logic                 issue_reg_write;
    logic [ADDR_W-1:0]    issue_dest;
    logic [ADDR_W-1:0]    src_a;
    logic [ADDR_W-1:0]    src_b;
    logic                 wb_valid;
    logic [ADDR_W-1:0]    wb_dest;
    logic                 stall;
    logic [NUM_REGS-1:0]  busy;
    logic [PCNT_W-1:0]    pending_count;
    logic                 underflow_err;

    // Pipeline side: presents issue and write-back, observes hazard status.
    modport master (
        output issue_valid, issue_reg_write, issue_dest, src_a, src_b,
        output wb_valid, wb_dest,
        input  stall, busy, pending_count, underflow_err
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_reg_write, issue_dest, src_a, src_b,
        input  wb_valid, wb_dest,
        output stall, busy, pending_count, underflow_err
    );
endinterface

// File: rtl/reg_dest_scoreboard_counter.sv
// Outstanding-write counter for one architectural register.
module sb_reg_counter
    import reg_dest_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             zero
);
    assign sat  = (cnt == CNT_MAX);
    assign zero = (cnt == '0);

    // Up/down count; simultaneous inc and dec cancel, and the ends clamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (!sat)  cnt <= cnt + 1'b1;
                2'b01:   if (!zero) cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/reg_dest_scoreboard.sv
// Destination scoreboard: counts in-flight register writes, raises stall on
// source/destination hazards, tracks the total in flight and flags write-backs
// that have no matching issue.
module reg_dest_scoreboard
    import reg_dest_scoreboard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    reg_dest_scoreboard_if.slave  sb
);
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            sat;
    logic [NUM_REGS-1:0]            zero;
    logic [NUM_REGS-1:1]            inc_v;
    logic [NUM_REGS-1:1]            dec_v;
    logic [NUM_REGS-1:0]            busy;
    logic [PCNT_W-1:0]              pending_q;
    logic                           underflow_q;

    logic dest_sat, src_hit, accept;
    logic inc_evt, wb_evt, same_reg, dec_evt, underflow_set;

    // Register 0 is hardwired zero and is never tracked.
    assign cnt[0]  = '0;
    assign sat[0]  = 1'b0;
    assign zero[0] = 1'b1;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        assign inc_v[i] = inc_evt && (sb.issue_dest == ADDR_W'(i));
        assign dec_v[i] = wb_evt  && (sb.wb_dest    == ADDR_W'(i));

        sb_reg_counter u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (inc_v[i]),
            .dec  (dec_v[i]),
            .cnt  (cnt[i]),
            .sat  (sat[i]),
            .zero (zero[i])
        );
    end

    assign busy = ~zero;

    // Hazard check uses registered counter state only; no write-back bypass.
    assign src_hit  = busy[sb.src_a] | busy[sb.src_b];
    assign dest_sat = sb.issue_reg_write & (sb.issue_dest != ZERO_REG) & sat[sb.issue_dest];
    assign sb.stall = sb.issue_valid & (src_hit | dest_sat);
    assign accept   = sb.issue_valid & ~sb.stall;

    // Qualified events. An issue and write-back to the same register cancel,
    // and the issue covers a write-back that would otherwise underflow.
    assign inc_evt       = accept & sb.issue_reg_write & (sb.issue_dest != ZERO_REG);
    assign wb_evt        = sb.wb_valid & (sb.wb_dest != ZERO_REG);
    assign same_reg      = inc_evt & wb_evt & (sb.issue_dest == sb.wb_dest);
    assign dec_evt       = wb_evt & (~zero[sb.wb_dest] | same_reg);
    assign underflow_set = wb_evt & zero[sb.wb_dest] & ~same_reg;

    // Running total of outstanding writes across all registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_q + PCNT_W'(inc_evt) - PCNT_W'(dec_evt);
    end

    // Sticky error for a write-back with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             underflow_q <= 1'b0;
        else if (underflow_set) underflow_q <= 1'b1;
    end

    assign sb.busy          = busy;
    assign sb.pending_count = pending_q;
    assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Randomized + directed bench against an array-of-counts reference model.
module tb_reg_dest_scoreboard;
    import reg_dest_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_dest_scoreboard_if sb_if ();

    reg_dest_scoreboard dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sb_if.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding writes per register and sticky error.
    int m_cnt [NUM_REGS];
    bit m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
        m_err = 0;
    endfunction

    function automatic bit model_stall(bit iv, bit rw, int d, int a, int b);
        bit hz;
        hz = (a != 0 && m_cnt[a] != 0) || (b != 0 && m_cnt[b] != 0) ||
             (rw && d != 0 && m_cnt[d] == 3);
        return iv && hz;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < NUM_REGS; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    function automatic int model_pending();
        int s;
        s = 0;
        for (int i = 0; i < NUM_REGS; i++) s += m_cnt[i];
        return s;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".busy"}, 64'(sb_if.busy), 64'(model_busy()));
        chk({tag, ".pend"}, 64'(sb_if.pending_count), 64'(model_pending()));
        chk({tag, ".uerr"}, 64'(sb_if.underflow_err), 64'(m_err));
    endtask

    // One cycle: drive at negedge, check stall, clock, update model, check state.
    task automatic drive(input string tag, input bit iv, input bit rw, input int d,
                         input int a, input int b, input bit wv, input int wd);
        bit st, inc, wbe;
        sb_if.issue_valid     = iv;
        sb_if.issue_reg_write = rw;
        sb_if.issue_dest      = ADDR_W'(d);
        sb_if.src_a           = ADDR_W'(a);
        sb_if.src_b           = ADDR_W'(b);
        sb_if.wb_valid        = wv;
        sb_if.wb_dest         = ADDR_W'(wd);
        #1;
        st = model_stall(iv, rw, d, a, b);
        chk({tag, ".stall"}, 64'(sb_if.stall), 64'(st));
        @(posedge clk);
        inc = iv && !st && rw && d != 0;
        wbe = wv && wd != 0;
        if (!(inc && wbe && d == wd)) begin
            if (wbe) begin
                if (m_cnt[wd] > 0) m_cnt[wd]--;
                else               m_err = 1;
            end
            if (inc) m_cnt[d]++;
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle();
        drive("idle", 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        sb_if.issue_valid = 0; sb_if.issue_reg_write = 0; sb_if.issue_dest = '0;
        sb_if.src_a = '0; sb_if.src_b = '0; sb_if.wb_valid = 0; sb_if.wb_dest = '0;
        repeat (2) @(negedge clk);
        check_state("rst");
        rst_n = 1'b1;

        // Reset mid-stream after three issues.
        drive("pre1", 1, 1, 4, 0, 0, 0, 0);
        drive("pre2", 1, 1, 5, 0, 0, 0, 0);
        drive("pre3", 1, 1, 6, 0, 0, 0, 0);
        chk("pre.pend3", 64'(sb_if.pending_count), 64'd3);
        #2 rst_n = 1'b0;
        sb_if.issue_valid = 1; sb_if.issue_reg_write = 0; sb_if.src_a = 5; sb_if.src_b = 0;
        #1;
        model_reset();
        chk("arst.busy", 64'(sb_if.busy), 64'd0);
        chk("arst.pend", 64'(sb_if.pending_count), 64'd0);
        chk("arst.uerr", 64'(sb_if.underflow_err), 64'd0);
        chk("arst.stall", 64'(sb_if.stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Write-back for a pre-reset issue must now underflow.
        drive("post_wb", 0, 0, 0, 0, 0, 1, 4);
        chk("post_wb.err", 64'(sb_if.underflow_err), 64'd1);
        #2 rst_n = 1'b0; #1 model_reset();
        @(negedge clk); rst_n = 1'b1;

        // RAW stall and release one cycle after the write-back edge.
        drive("raw_iss", 1, 1, 8, 0, 0, 0, 0);
        drive("raw_st1", 1, 0, 0, 8, 0, 0, 0);
        drive("raw_st2", 1, 0, 0, 0, 8, 1, 8);
        drive("raw_rel", 1, 0, 0, 8, 0, 0, 0);
        chk("raw.pend0", 64'(sb_if.pending_count), 64'd0);

        // Zero register is never tracked.
        drive("z_iss", 1, 1, 0, 0, 0, 0, 0);
        drive("z_src", 1, 0, 0, 0, 0, 0, 0);
        chk("z.busy0", 64'(sb_if.busy[0]), 64'd0);

        // Saturation of register 3.
        drive("sat1", 1, 1, 3, 0, 0, 0, 0);
        drive("sat2", 1, 1, 3, 0, 0, 0, 0);
        drive("sat3", 1, 1, 3, 0, 0, 0, 0);
        chk("sat.busy3", 64'(sb_if.busy[3]), 64'd1);
        chk("sat.pend3", 64'(sb_if.pending_count), 64'd3);
        drive("sat4", 1, 1, 3, 0, 0, 0, 0);
        chk("sat4.pend", 64'(sb_if.pending_count), 64'd3);
        repeat (3) drive("sat_wb", 0, 0, 0, 0, 0, 1, 3);

        // Simultaneous issue and write-back on the same register.
        drive("sim_pre", 1, 1, 12, 0, 0, 0, 0);
        drive("sim_both", 1, 1, 12, 0, 0, 1, 12);
        chk("sim.pend", 64'(sb_if.pending_count), 64'd1);
        drive("sim_zero", 1, 1, 13, 0, 0, 1, 13);
        chk("sim.noerr", 64'(sb_if.underflow_err), 64'd0);

        // Underflow is sticky through later traffic.
        drive("uf", 0, 0, 0, 0, 0, 1, 20);
        chk("uf.set", 64'(sb_if.underflow_err), 64'd1);
        drive("uf_hold1", 1, 1, 9, 0, 0, 1, 12);
        drive("uf_hold2", 1, 1, 10, 0, 0, 1, 9);
        idle();

        // Randomized traffic over a small register window to hit hazards.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2 rst_n = 1'b0; #1 model_reset();
                check_state("rnd_rst");
                @(negedge clk); rst_n = 1'b1;
            end
            drive("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
